operand_select_ctrl: RTL

//  Generates the select lines consumed by the EX-stage operand 2:1/3:1 muxes and
//  the load-use stall/bubble controls of the 5-stage MIPS pipeline. Tracks the

---
 rtl/operand_select_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/operand_select_ctrl.sv
// operand_select_ctrl
//   Drives the select lines of the EX-stage operand muxes and the load-use
//   stall/bubble controls for a 5-stage MIPS pipeline. The destination
//   register and write/load flags of the instructions in EX, MEM and WB are
//   tracked internally, so the block needs only the ID-stage decode fields.
//
// Ports
//   Clk, Rst_n          rising-edge clock, asynchronous active-low reset
//   ID_Valid            ID holds a real instruction (0 = bubble)
//   ID_Rs, ID_Rt        source registers of the ID instruction
//   ID_Uses_Rt          ID instruction reads Rt as an operand
//   ID_Dest             destination register of the ID instruction
//   ID_RegWrite         ID instruction writes the register file
//   ID_MemRead          ID instruction is a load
//   ID_Branch           ID instruction is a branch comparing Rs/Rt in ID
//   ForwardA/ForwardB   EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   Stall               hold PC and IF/ID this cycle
//   Bubble              load a NOP into ID/EX at the next edge (== Stall)
//   Stall_Count         stalled cycles since reset, saturating
//
// Build option
//   BRANCH_HAZARD_EN    when defined, a branch in ID also stalls until its
//                       source operands can be read in ID (ALU producer in
//                       EX: 1 cycle; load in EX: 2 cycles; load in MEM: 1).
//                       When undefined, ID_Branch is ignored.

module operand_select_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_Uses_Rt,
    input  logic [REG_AW-1:0] ID_Dest,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_Branch,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              Stall,
    output logic              Bubble,
    output logic [CNT_W-1:0]  Stall_Count
);

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rw;
        logic              mr;
    } ex_slot_t;

    ex_slot_t          ex_q;
    logic [REG_AW-1:0] mem_dest, wb_dest;
    logic              mem_rw, mem_mr, wb_rw;
    logic              load_use, branch_hz;

    // Load in EX whose result the ID instruction needs in EX next cycle.
    always_comb begin
        load_use = ID_Valid && ex_q.mr && (ex_q.dest != '0) &&
                   ((ex_q.dest == ID_Rs) || (ID_Uses_Rt && (ex_q.dest == ID_Rt)));
    end

`ifdef BRANCH_HAZARD_EN
    // A branch compares in ID, so any producer still in EX, or a load still
    // in MEM, has not made its value available yet.
    function automatic logic src_pending(input logic [REG_AW-1:0] r,
                                         input ex_slot_t          ex,
                                         input logic [REG_AW-1:0] mdest,
                                         input logic              mmr);
        return (r != '0) &&
               (((ex.rw || ex.mr) && (ex.dest == r)) || (mmr && (mdest == r)));
    endfunction

    always_comb begin
        branch_hz = ID_Valid && ID_Branch &&
                    (src_pending(ID_Rs, ex_q, mem_dest, mem_mr) ||
                     src_pending(ID_Rt, ex_q, mem_dest, mem_mr));
    end
`else
    // Branch input is read but has no effect in this build.
    always_comb begin
        branch_hz = ID_Branch & 1'b0;
    end
`endif

    always_comb begin
        Stall  = load_use || branch_hz;
        Bubble = Stall;
    end

    // Newest producer (EX/MEM) takes priority; r0 and bubbles never forward.
    always_comb begin
        ForwardA = 2'b00;
        if (mem_rw && (mem_dest != '0) && (mem_dest == ex_q.rs))
            ForwardA = 2'b10;
        else if (wb_rw && (wb_dest != '0) && (wb_dest == ex_q.rs))
            ForwardA = 2'b01;

        ForwardB = 2'b00;
        if (mem_rw && (mem_dest != '0) && (mem_dest == ex_q.rt))
            ForwardB = 2'b10;
        else if (wb_rw && (wb_dest != '0) && (wb_dest == ex_q.rt))
            ForwardB = 2'b01;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_q        <= '0;
            mem_dest    <= '0;
            mem_rw      <= 1'b0;
            mem_mr      <= 1'b0;
            wb_dest     <= '0;
            wb_rw       <= 1'b0;
            Stall_Count <= '0;
        end else begin
            wb_dest  <= mem_dest;
            wb_rw    <= mem_rw;
            mem_dest <= ex_q.dest;
            mem_rw   <= ex_q.rw;
            mem_mr   <= ex_q.mr;
            if (!Stall && ID_Valid) begin
                ex_q.dest <= ID_Dest;
                ex_q.rs   <= ID_Rs;
                ex_q.rt   <= ID_Rt;
                ex_q.rw   <= ID_RegWrite;
                ex_q.mr   <= ID_MemRead;
            end else begin
                ex_q <= '0;
            end
            if (Stall && (Stall_Count != {CNT_W{1'b1}}))
                Stall_Count <= Stall_Count + 1'b1;
        end
    end

endmodule
